// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline-side bundle for the hazard controller
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             icache_hit;
   logic             dcache_hit;
   logic             id_valid;
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic             id_uses_rs1;
   logic             id_uses_rs2;
   logic [4:0]       ex_rd;
   logic [6:0]       ex_opcode;
   logic             ex_noop;
   logic             redirect;
   logic             hit;
   logic             idex_stall;
   logic             ifid_hold;
   logic             flush;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;
   logic [CNT_W-1:0] miss_count;

   // pipeline side: reports stage contents, consumes control
   modport master (
      output icache_hit, dcache_hit, id_valid, id_rs1, id_rs2, id_uses_rs1,
             id_uses_rs2, ex_rd, ex_opcode, ex_noop, redirect,
      input  hit, idex_stall, ifid_hold, flush, state,
             stall_count, flush_count, miss_count
   );

   // controller side
   modport slave (
      input  icache_hit, dcache_hit, id_valid, id_rs1, id_rs2, id_uses_rs1,
             id_uses_rs2, ex_rd, ex_opcode, ex_noop, redirect,
      output hit, idex_stall, ifid_hold, flush, state,
             stall_count, flush_count, miss_count
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use / redirect / cache-miss hazard controller
module pipe_hazard_ctrl #(
   parameter logic [6:0] LOAD_OPCODE  = 7'b0000011,
   parameter int         FLUSH_CYCLES = 2,
   parameter int         CNT_W        = 32
) (
   input  logic              clk,
   input  logic              reset,
   pipe_hazard_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
   localparam state_t     REDIR_STATE  = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

   state_t           state_q, state_d;
   logic [2:0]       fcnt_q, fcnt_d;
   logic             hit;
   logic             lu;
   logic             stall_o, hold_o, flush_o;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, miss_cnt_q;

   assign hit = bus.icache_hit & bus.dcache_hit;

   // a load in EX whose destination is read by the real instruction in ID
   assign lu = (bus.ex_opcode == LOAD_OPCODE) & ~bus.ex_noop & (bus.ex_rd != 5'd0) & bus.id_valid &
               ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd)));

   // control outputs and next state; a frozen pipeline holds everything
   always_comb begin
      stall_o = 1'b0;
      hold_o  = 1'b0;
      flush_o = 1'b0;
      state_d = state_q;
      fcnt_d  = fcnt_q;
      if (hit) begin
         case (state_q)
            RUN: begin
               if (bus.redirect) begin
                  flush_o = 1'b1;
                  fcnt_d  = FLUSH_RELOAD;
                  state_d = REDIR_STATE;
               end else if (lu) begin
                  stall_o = 1'b1;
                  hold_o  = 1'b1;
                  state_d = LU_STALL;
               end else begin
                  state_d = RUN;
               end
            end
            LU_STALL: begin
               if (bus.redirect) begin
                  flush_o = 1'b1;
                  fcnt_d  = FLUSH_RELOAD;
                  state_d = REDIR_STATE;
               end else begin
                  state_d = RUN;
               end
            end
            FLUSH: begin
               flush_o = 1'b1;
               if (bus.redirect) begin
                  fcnt_d  = FLUSH_RELOAD;
                  state_d = REDIR_STATE;
               end else begin
                  fcnt_d = (fcnt_q != 3'd0) ? fcnt_q - 3'd1 : 3'd0;
                  if (fcnt_q <= 3'd1) state_d = RUN;
               end
            end
            default: begin
               state_d = RUN;
               fcnt_d  = 3'd0;
            end
         endcase
      end
   end

   // FSM and flush down-counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         fcnt_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
      end
   end

   // saturating event counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         miss_cnt_q  <= '0;
      end else begin
         if (hit && stall_o && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (hit && flush_o && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         if (!hit && (miss_cnt_q != '1))            miss_cnt_q  <= miss_cnt_q + CNT_W'(1);
      end
   end

   assign bus.hit         = hit;
   assign bus.idex_stall  = stall_o;
   assign bus.ifid_hold   = hold_o;
   assign bus.flush       = flush_o;
   assign bus.state       = state_q;
   assign bus.stall_count = stall_cnt_q;
   assign bus.flush_count = flush_cnt_q;
   assign bus.miss_count  = miss_cnt_q;

endmodule
